// File: rtl/uart_rx_fifo.sv
// Byte FIFO behind a UART receiver.
// One write per rx_done rising edge, registered reads, sticky overrun.
module uart_rx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] rx_data,
  input  logic             rx_done,
  input  logic             rd_en,
  input  logic             ovr_clr,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             empty,
  output logic             full,
  output logic [AW:0]      count,
  output logic             overrun
);

  localparam logic [AW:0] LP_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic [WIDTH-1:0] r_dout;
  logic             r_dout_valid;
  logic             r_overrun;
  logic             r_done_q;

  logic w_wr_pulse;
  logic w_rd_acc;
  logic w_wr_acc;
  logic w_drop;

  assign empty = (r_count == '0);
  assign full  = (r_count == LP_FULL);

  assign w_wr_pulse = rx_done & ~r_done_q;
  assign w_rd_acc   = rst & rd_en & ~empty;
  // a read frees the slot the full-case write lands in
  assign w_wr_acc   = rst & w_wr_pulse & (~full | w_rd_acc);
  assign w_drop     = rst & w_wr_pulse & full & ~w_rd_acc;

  always_ff @(posedge clk) begin
    if (w_wr_acc)
      r_mem[r_wr_ptr] <= rx_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_done_q     <= 1'b1;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_done_q     <= rx_done;
      r_dout_valid <= w_rd_acc;
      if (w_wr_acc)
        r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_acc) begin
        r_dout   <= r_mem[r_rd_ptr];
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      unique case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_drop)
        r_overrun <= 1'b1;
      else if (ovr_clr)
        r_overrun <= 1'b0;
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign count      = r_count;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo.
// Vector table for single-cycle behaviour, sequences for fill/wrap/reset.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       rd_en;
  logic       ovr_clr;
  logic [7:0] dout;
  logic       dout_valid;
  logic       empty;
  logic       full;
  logic [3:0] count;
  logic       overrun;

  int n_chk  = 0;
  int n_fail = 0;

  uart_rx_fifo #(.DEPTH(8), .WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_done    (rx_done),
    .rd_en      (rd_en),
    .ovr_clr    (ovr_clr),
    .dout       (dout),
    .dout_valid (dout_valid),
    .empty      (empty),
    .full       (full),
    .count      (count),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       done;
    logic [7:0] data;
    logic       rd;
    logic       clr;
    logic [3:0] c;
    logic       e;
    logic       f;
    logic       dv;
    logic       ov;
    logic       cd;
    logic [7:0] dout;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; rx_done = 1'b0; rd_en = 1'b0; ovr_clr = 1'b0;
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic write_byte(input logic [7:0] d);
    rx_data = d; rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    tick();
  endtask

  task automatic read_chk(input string nm, input logic [7:0] d);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk({nm, "_dout"}, dout, d);
    chk({nm, "_dv"}, dout_valid, 1'b1);
  endtask

  initial begin
    rst = 1'b0; rx_done = 1'b0; rx_data = 8'h00;
    rd_en = 1'b0; ovr_clr = 1'b0;

    //          rst done data  rd clr  c  e f dv ov cd dout
    tbl[0]  = '{0, 0, 8'h00, 0, 0, 0, 1, 0, 0, 0, 1, 8'h00};
    tbl[1]  = '{0, 1, 8'h11, 0, 0, 0, 1, 0, 0, 0, 1, 8'h00};
    tbl[2]  = '{1, 1, 8'hA5, 0, 0, 0, 1, 0, 0, 0, 0, 8'h00};
    tbl[3]  = '{1, 0, 8'hA5, 0, 0, 0, 1, 0, 0, 0, 0, 8'h00};
    tbl[4]  = '{1, 0, 8'h00, 1, 0, 0, 1, 0, 0, 0, 1, 8'h00};
    tbl[5]  = '{1, 1, 8'hA5, 0, 0, 1, 0, 0, 0, 0, 0, 8'h00};
    tbl[6]  = '{1, 1, 8'h77, 0, 0, 1, 0, 0, 0, 0, 0, 8'h00};
    tbl[7]  = '{1, 1, 8'h77, 1, 0, 0, 1, 0, 1, 0, 1, 8'hA5};
    tbl[8]  = '{1, 0, 8'h00, 0, 0, 0, 1, 0, 0, 0, 1, 8'hA5};
    tbl[9]  = '{1, 1, 8'h3C, 1, 0, 1, 0, 0, 0, 0, 1, 8'hA5};
    tbl[10] = '{1, 0, 8'h00, 1, 0, 0, 1, 0, 1, 0, 1, 8'h3C};
    tbl[11] = '{1, 0, 8'h00, 0, 1, 0, 1, 0, 0, 0, 1, 8'h3C};

    for (int i = 0; i < 12; i++) begin
      rst = tbl[i].rst; rx_done = tbl[i].done; rx_data = tbl[i].data;
      rd_en = tbl[i].rd; ovr_clr = tbl[i].clr;
      tick();
      chk($sformatf("v%0d_count", i), count, tbl[i].c);
      chk($sformatf("v%0d_empty", i), empty, tbl[i].e);
      chk($sformatf("v%0d_full", i), full, tbl[i].f);
      chk($sformatf("v%0d_dv", i), dout_valid, tbl[i].dv);
      chk($sformatf("v%0d_ovr", i), overrun, tbl[i].ov);
      if (tbl[i].cd)
        chk($sformatf("v%0d_dout", i), dout, tbl[i].dout);
    end
    rd_en = 1'b0; ovr_clr = 1'b0; rx_done = 1'b0;

    // long rx_done level produces a single entry
    do_reset();
    rx_data = 8'hA5; rx_done = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk($sformatf("hold%0d_count", i), count, 4'd1);
    end
    rx_done = 1'b0;
    read_chk("hold_rd", 8'hA5);
    chk("hold_empty", empty, 1'b1);
    tick();
    chk("hold_dv_drop", dout_valid, 1'b0);

    // fill, overrun drop, set-wins-over-clear, ordered drain
    for (int i = 1; i <= 8; i++) write_byte(8'(i));
    chk("fill_full", full, 1'b1);
    chk("fill_count", count, 4'd8);
    chk("fill_ovr", overrun, 1'b0);
    write_byte(8'hFF);
    chk("ovr_set", overrun, 1'b1);
    chk("ovr_count", count, 4'd8);
    rx_data = 8'hEE; rx_done = 1'b1; ovr_clr = 1'b1;
    tick();
    rx_done = 1'b0; ovr_clr = 1'b0;
    chk("ovr_setwins", overrun, 1'b1);
    tick();
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    chk("ovr_clr", overrun, 1'b0);
    for (int i = 1; i <= 8; i++)
      read_chk($sformatf("drain%0d", i), 8'(i));
    chk("drain_empty", empty, 1'b1);
    chk("drain_count", count, 4'd0);

    // simultaneous write and read while full
    for (int i = 1; i <= 8; i++) write_byte(8'(i));
    rx_data = 8'h55; rx_done = 1'b1; rd_en = 1'b1;
    tick();
    rx_done = 1'b0; rd_en = 1'b0;
    chk("sim_count", count, 4'd8);
    chk("sim_ovr", overrun, 1'b0);
    chk("sim_dout", dout, 8'h01);
    chk("sim_dv", dout_valid, 1'b1);
    tick();
    for (int i = 2; i <= 8; i++)
      read_chk($sformatf("sim_rd%0d", i), 8'(i));
    read_chk("sim_last", 8'h55);
    chk("sim_empty", empty, 1'b1);

    // pointer wrap over many pairs
    for (int i = 0; i < 20; i++) begin
      write_byte(8'h80 + 8'(i));
      read_chk($sformatf("wrap%0d", i), 8'h80 + 8'(i));
    end
    chk("wrap_count", count, 4'd0);
    chk("wrap_ovr", overrun, 1'b0);

    // reset mid-operation with receiver still high
    for (int i = 0; i < 3; i++) write_byte(8'hC0 + 8'(i));
    chk("mid_count3", count, 4'd3);
    rx_data = 8'hDD; rx_done = 1'b1; rd_en = 1'b1; rst = 1'b0;
    tick();
    rst = 1'b1; rd_en = 1'b0;
    chk("mid_count", count, 4'd0);
    chk("mid_empty", empty, 1'b1);
    chk("mid_dv", dout_valid, 1'b0);
    chk("mid_dout", dout, 8'h00);
    tick();
    tick();
    chk("mid_nowr", count, 4'd0);
    rx_done = 1'b0;
    tick();
    chk("mid_nowr2", empty, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
